mem_cmd_master: RTL
===================

MEM_CMD_MASTER -- requirements
Module: mem_cmd_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, RAM address width; legal range 1..8.
REQ-002 Parameter TIMEOUT, default 255, idle cycles allowed between bytes of one command; legal range 1..65535.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_l  input  1  reset, synchronous and active-low.
REQ-005 rx_valid  input  1  command byte available.
REQ-006 rx_data  input  8  command byte.
REQ-007 rx_ready  output  1  block accepts rx_data this cycle.
REQ-008 tx_valid  output  1  response byte available.
REQ-009 tx_data  output  8  response byte.
REQ-010 tx_ready  input  1  downstream accepts tx_data.
REQ-011 mem_wr  output  1  RAM write strobe.
REQ-012 mem_addr  output  ADDR_WIDTH  RAM address.
REQ-013 mem_wdata  output  8  RAM write data.
REQ-014 mem_rdata  input  8  RAM read data; valid only while mem_wr=0.
REQ-015 timeout_pulse  output  1  one-cycle flag: command abandoned.

Function
REQ-016 Byte transfer on rx occurs when rx_valid&&rx_ready; transfer on tx occurs when tx_valid&&tx_ready.
REQ-017 FSM states: S_OP, S_ADDR, S_DATA, S_WR, S_RD, S_RESP.
REQ-018 rx_ready=1 only in S_OP, S_ADDR and S_DATA.
REQ-019 S_OP: accepted 0x57 ('W') -> S_ADDR with write flag set; accepted 0x52 ('R') -> S_ADDR with write flag clear; any other byte -> S_RESP with tx_data=0x45 ('E').
REQ-020 S_ADDR: accepted byte >= 2**ADDR_WIDTH -> S_RESP with tx_data=0x45; otherwise latch mem_addr, then -> S_DATA if write, else -> S_RD.
REQ-021 S_DATA: accepted byte latched into mem_wdata -> S_WR.
REQ-022 S_WR: mem_wr=1 for exactly one cycle with mem_addr/mem_wdata stable -> S_RESP with tx_data=0x4B ('K').
REQ-023 S_RD: mem_wr=0; mem_rdata registered into tx_data at cycle end -> S_RESP; latency from address accept to tx_valid = 2 cycles.
REQ-024 S_RESP: tx_valid=1, tx_data held stable until accepted; on accept -> S_OP; accept and next command byte never overlap (rx_ready=0 in S_RESP).
REQ-025 mem_wr=0 in every state except S_WR; mem_addr and mem_wdata hold last latched value outside S_WR/S_RD.
REQ-026 Timeout counter: cleared on every rx transfer and on entry to S_ADDR/S_DATA; increments each cycle in S_ADDR/S_DATA with no transfer; on reaching TIMEOUT -> S_OP, no response, timeout_pulse=1 for one cycle.
REQ-027 Counter width = $clog2(TIMEOUT+1); counter never wraps.
REQ-028 Timeout and rx transfer in the same cycle: transfer wins, no timeout.
REQ-029 Out-of-range address test compares the full 8-bit byte; upper bits never silently truncated.

Reset
REQ-030 rst_l=0 at a rising edge -> state S_OP, rx_ready=1 in the cycle following reset release, tx_valid=0, tx_data=0, mem_wr=0, mem_addr=0, mem_wdata=0, timeout_pulse=0, counter=0.
REQ-031 Reset in any state, including S_WR and S_RESP, abandons the command; no write or response issued after reset asserts.

Structure
REQ-032 Shared package mem_cmd_pkg holds the state enum, opcode constants (0x57, 0x52) and response constants (0x4B, 0x45).
REQ-033 One sub-module, cmd_timeout_ctr (clear/enable/expire counter), parameterised by TIMEOUT.
REQ-034 Block connects directly to RAM wr/addr/wdata/rdata with matching ADDR_WIDTH and data width 8.

Verification
REQ-035 Send 0x57,0x03,0xA5 then 0x52,0x03 -> mem_wr one cycle at addr 3 data 0xA5, tx 0x4B; then tx 0xA5.
REQ-036 Send 0x11 -> tx 0x45, no mem_wr; next 0x52,0x00 after reset -> tx 0x00.
REQ-037 ADDR_WIDTH=4, send 0x57,0x10 -> tx 0x45, no S_DATA, no mem_wr.
REQ-038 Read with tx_ready low 10 cycles -> tx_valid and tx_data stable all 10 cycles, rx_ready=0 throughout.
REQ-039 TIMEOUT=8, send 0x57 then no bytes -> timeout_pulse after 8 idle cycles, no tx, next 0x52,0x00 served normally.
REQ-040 rst_l low during S_DATA of write to addr 5 -> no mem_wr, read of addr 5 returns prior value.

Source files
------------

// File: rtl/mem_cmd_pkg.sv
// Shared types and byte constants for the byte-serial RAM command master.
package mem_cmd_pkg;

    typedef enum logic [2:0] {
        S_OP,
        S_ADDR,
        S_DATA,
        S_WR,
        S_RD,
        S_RESP
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RESP_OK  = 8'h4B;
    localparam logic [7:0] RESP_ERR = 8'h45;

    // Whole received byte is tested so high bits can never alias onto a legal address.
    function automatic logic addr_in_range(input logic [7:0] b, input int unsigned aw);
        return (b >> aw) == 8'd0;
    endfunction

endpackage

// File: rtl/mem_cmd_master_if.sv
// Byte stream in/out plus the RAM port driven by the command master.
interface mem_cmd_master_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  tx_ready;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;
    logic                  timeout_pulse;

    modport master (
        input  rx_valid, rx_data, tx_ready, mem_rdata,
        output rx_ready, tx_valid, tx_data, mem_wr, mem_addr, mem_wdata, timeout_pulse
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, mem_rdata,
        input  rx_ready, tx_valid, tx_data, mem_wr, mem_addr, mem_wdata, timeout_pulse
    );
endinterface

// File: rtl/cmd_timeout_ctr.sv
// Saturating idle counter: clear wins over enable, expired while the count sits at TIMEOUT.
module cmd_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_l,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);
endmodule

// File: rtl/mem_cmd_master.sv
// Parses 'W' addr data / 'R' addr byte commands, drives the RAM and returns one response byte.
module mem_cmd_master
    import mem_cmd_pkg::*;
#(
    parameter int          ADDR_WIDTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic              clk,
    input logic              rst_l,
    mem_cmd_master_if.master bus
);
    state_t                state_q, state_d;
    logic                  wr_flag_q, wr_flag_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  rx_ready_c, rx_fire, tx_valid_c, tx_fire;
    logic                  in_wait, expired, timeout_c;

    assign rx_ready_c = (state_q == S_OP) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign in_wait    = (state_q == S_ADDR) || (state_q == S_DATA);
    assign rx_fire    = bus.rx_valid && rx_ready_c;
    // Gated by rst_l so nothing leaves the block once reset is asserted.
    assign tx_valid_c = (state_q == S_RESP) && rst_l;
    assign tx_fire    = tx_valid_c && bus.tx_ready;

    cmd_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst_l  (rst_l),
        .clr    (rx_fire || !in_wait),
        .en     (in_wait),
        .expired(expired)
    );

    always_comb begin
        state_d   = state_q;
        wr_flag_d = wr_flag_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_data_d = tx_data_q;
        timeout_c = 1'b0;
        case (state_q)
            S_OP: begin
                if (rx_fire) begin
                    if (bus.rx_data == OP_WRITE) begin
                        wr_flag_d = 1'b1;
                        state_d   = S_ADDR;
                    end else if (bus.rx_data == OP_READ) begin
                        wr_flag_d = 1'b0;
                        state_d   = S_ADDR;
                    end else begin
                        tx_data_d = RESP_ERR;
                        state_d   = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    if (!addr_in_range(bus.rx_data, ADDR_WIDTH)) begin
                        tx_data_d = RESP_ERR;
                        state_d   = S_RESP;
                    end else begin
                        addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
                        state_d = wr_flag_q ? S_DATA : S_RD;
                    end
                end else if (expired) begin
                    timeout_c = 1'b1;
                    state_d   = S_OP;
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    wdata_d = bus.rx_data;
                    state_d = S_WR;
                end else if (expired) begin
                    timeout_c = 1'b1;
                    state_d   = S_OP;
                end
            end
            S_WR: begin
                tx_data_d = RESP_OK;
                state_d   = S_RESP;
            end
            S_RD: begin
                tx_data_d = bus.mem_rdata;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (tx_fire) state_d = S_OP;
            end
            default: state_d = S_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q   <= S_OP;
            wr_flag_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_flag_q <= wr_flag_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign bus.rx_ready      = rx_ready_c;
    assign bus.tx_valid      = tx_valid_c;
    assign bus.tx_data       = tx_data_q;
    assign bus.mem_wr        = (state_q == S_WR) && rst_l;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.timeout_pulse = timeout_c;
endmodule
